// File: rtl/dpram_arb_pkg.sv
// Shared defaults and the read-response tag type for the dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    // Wide enough to name any of up to eight requesters.
    localparam int IDX_W = 3;

    // One outstanding read per RAM port: which requester the returning data belongs to.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/dpram_arbiter_rr_pick2.sv
// Round-robin two-winner finder: first and second active requests scanning
// upward from the pointer, with wrap, stopping before the pointer again.
module rr_pick2 #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    a_idx,
    output logic             a_vld,
    output logic [PW-1:0]    b_idx,
    output logic             b_vld
);

    // Walk the N_REQ slots once from ptr; the first hit is A, the second is B.
    always_comb begin
        int idx;
        idx   = 0;
        a_idx = '0;
        a_vld = 1'b0;
        b_idx = '0;
        b_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = PW'(idx);
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM among N_REQ requesters: up to two round-robin
// grants per cycle (first to port A, second to port B), same-address hazard
// blocking, and read-data routing back to the issuing requester.
//
// Request handshake: req[i] together with its we/addr/wdata slot is a
// request that stays asserted and stable until accepted; a request is
// accepted exactly in a cycle where req[i] && gnt[i]. gnt is combinational
// from the current req. In the following cycle the requester either drops
// req[i] or presents its next request. Read data comes back as rsp_valid[i]
// one cycle after acceptance, with no back-pressure.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [N_REQ*DW-1:0] rsp_data,
    output logic [AW-1:0]       ram_addr_a,
    output logic [AW-1:0]       ram_addr_b,
    output logic [DW-1:0]       ram_din_a,
    output logic [DW-1:0]       ram_din_b,
    output logic                ram_we_a,
    output logic                ram_we_b,
    output logic                ram_re_a,
    output logic                ram_re_b,
    input  logic [DW-1:0]       ram_dout_a,
    input  logic [DW-1:0]       ram_dout_b,
    output logic [CW-1:0]       conflict_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] a_idx, b_idx;
    logic          a_vld, b_vld;

    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_we, b_we;
    logic          hazard;
    logic          a_gnt, b_gnt;

    tag_t          tag_a, tag_b;

    rr_pick2 #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .a_idx (a_idx),
        .a_vld (a_vld),
        .b_idx (b_idx),
        .b_vld (b_vld)
    );

    // Wrap-around increment of a requester index.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
        if (int'(v) == N_REQ - 1) return '0;
        return v + 1'b1;
    endfunction

    assign a_addr  = req_addr[a_idx*AW +: AW];
    assign b_addr  = req_addr[b_idx*AW +: AW];
    assign a_wdata = req_wdata[a_idx*DW +: DW];
    assign b_wdata = req_wdata[b_idx*DW +: DW];
    assign a_we    = req_we[a_idx];
    assign b_we    = req_we[b_idx];

    // B is deferred when both winners touch one address and either writes;
    // two reads of the same address are harmless and both go through.
    assign hazard = a_vld && b_vld && (a_addr == b_addr) && (a_we || b_we);
    assign a_gnt  = rst && a_vld;
    assign b_gnt  = rst && b_vld && !hazard;

    // Grant vector: one bit per accepted request.
    always_comb begin
        gnt = '0;
        if (a_gnt) gnt[a_idx] = 1'b1;
        if (b_gnt) gnt[b_idx] = 1'b1;
    end

    // Drive the RAM pins from each port's winner; idle ports drive zeros.
    always_comb begin
        ram_addr_a = '0;
        ram_din_a  = '0;
        ram_we_a   = 1'b0;
        ram_re_a   = 1'b0;
        ram_addr_b = '0;
        ram_din_b  = '0;
        ram_we_b   = 1'b0;
        ram_re_b   = 1'b0;
        if (a_gnt) begin
            ram_addr_a = a_addr;
            ram_din_a  = a_wdata;
            ram_we_a   = a_we;
            ram_re_a   = !a_we;
        end
        if (b_gnt) begin
            ram_addr_b = b_addr;
            ram_din_b  = b_wdata;
            ram_we_b   = b_we;
            ram_re_b   = !b_we;
        end
    end

    // Round-robin pointer moves just past the last requester served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (b_gnt) begin
            rr_ptr <= ptr_inc(b_idx);
        end else if (a_gnt) begin
            rr_ptr <= ptr_inc(a_idx);
        end
    end

    // Remember who issued each port's read so the data can be steered back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            tag_a.valid <= a_gnt && !a_we;
            tag_a.idx   <= IDX_W'(a_idx);
            tag_b.valid <= b_gnt && !b_we;
            tag_b.idx   <= IDX_W'(b_idx);
        end
    end

    // Route returning read data to its requester; every other slot reads zero.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_a.valid && tag_a.idx == IDX_W'(i)) begin
                rsp_valid[i]          = 1'b1;
                rsp_data[i*DW +: DW]  = ram_dout_a;
            end else if (tag_b.valid && tag_b.idx == IDX_W'(i)) begin
                rsp_valid[i]          = 1'b1;
                rsp_data[i*DW +: DW]  = ram_dout_b;
            end
        end
    end

    // Saturating count of cycles in which a hazard deferred port B.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (hazard && conflict_cnt != {CW{1'b1}}) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus a randomized run against a
// list-based reference model; includes a behavioural 16x8 dual-port RAM.
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [DW-1:0]   ram_din_a, ram_din_b;
    logic            ram_we_a, ram_we_b, ram_re_a, ram_re_b;
    logic [DW-1:0]   ram_dout_a, ram_dout_b;
    logic [CW-1:0]   conflict_cnt;

    dpram_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_addr_a   (ram_addr_a),
        .ram_addr_b   (ram_addr_b),
        .ram_din_a    (ram_din_a),
        .ram_din_b    (ram_din_b),
        .ram_we_a     (ram_we_a),
        .ram_we_b     (ram_we_b),
        .ram_re_a     (ram_re_a),
        .ram_re_b     (ram_re_b),
        .ram_dout_a   (ram_dout_a),
        .ram_dout_b   (ram_dout_b),
        .conflict_cnt (conflict_cnt)
    );

    // ---------------- behavioural dual-port RAM ----------------
    logic          ram_clr = 1'b1;
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
            ram_dout_a <= '0;
            ram_dout_b <= '0;
        end else begin
            if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
            if (ram_we_b) ram_mem[ram_addr_b] <= ram_din_b;
            if (ram_re_a) ram_dout_a <= ram_mem[ram_addr_a];
            if (ram_re_b) ram_dout_b <= ram_mem[ram_addr_b];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int            n_checks = 0;
    int            n_pass = 0;
    int            m_ptr;
    int            m_cnt;
    logic [DW-1:0] m_mem [16];
    logic [10:0]   exp_q [$];     // {requester, data} of reads due next cycle
    logic [N-1:0]  m_rsp_v;
    logic [N*DW-1:0] m_rsp_d;
    int            e_wa, e_wb;
    bit            e_haz;
    logic [N-1:0]  e_gnt;
    logic [AW+DW+1:0] e_port_a, e_port_b;   // {addr, din, we, re}

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    // Evaluate one cycle from the current inputs: who should win and what
    // the RAM pins and responses should look like.
    function automatic void model_eval();
        int order[$];
        m_rsp_v = '0;
        m_rsp_d = '0;
        while (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            m_rsp_v[e[10:8]] = 1'b1;
            m_rsp_d[e[10:8]*DW +: DW] = e[7:0];
        end
        e_wa = -1; e_wb = -1; e_haz = 0;
        e_gnt = '0; e_port_a = '0; e_port_b = '0;
        if (rst) begin
            for (int k = 0; k < N; k++)
                if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
            if (order.size() > 0) e_wa = order[0];
            if (order.size() > 1) begin
                if (addr_of(order[0]) == addr_of(order[1]) && (req_we[order[0]] || req_we[order[1]]))
                    e_haz = 1;
                else
                    e_wb = order[1];
            end
            if (e_wa >= 0) begin
                e_gnt[e_wa] = 1'b1;
                e_port_a = {addr_of(e_wa), wdata_of(e_wa), req_we[e_wa], !req_we[e_wa]};
            end
            if (e_wb >= 0) begin
                e_gnt[e_wb] = 1'b1;
                e_port_b = {addr_of(e_wb), wdata_of(e_wb), req_we[e_wb], !req_we[e_wb]};
            end
        end
    endfunction

    // Apply the clock edge to the model state.
    function automatic void model_commit();
        if (!rst) begin
            m_ptr = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (e_wa >= 0 && !req_we[e_wa]) exp_q.push_back({3'(e_wa), m_mem[addr_of(e_wa)]});
            if (e_wb >= 0 && !req_we[e_wb]) exp_q.push_back({3'(e_wb), m_mem[addr_of(e_wb)]});
            if (e_wa >= 0 && req_we[e_wa]) m_mem[addr_of(e_wa)] = wdata_of(e_wa);
            if (e_wb >= 0 && req_we[e_wb]) m_mem[addr_of(e_wb)] = wdata_of(e_wb);
            if (e_wb >= 0) m_ptr = (e_wb + 1) % N;
            else if (e_wa >= 0) m_ptr = (e_wa + 1) % N;
            if (e_haz && m_cnt < CNT_MAX) m_cnt++;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req();
        req = '0;
        req_we = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic apply_reset();
        clr_req();
        rst = 1'b0;
        @(posedge clk);
        model_commit();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        req = 4'hF;
        settle();
        n_checks++; if (gnt !== 4'h0) $display("FAIL rst_gnt: got %h expected 0", gnt); else n_pass++;
        n_checks++; if (rsp_valid !== 4'h0) $display("FAIL rst_rsp_valid: got %h expected 0", rsp_valid); else n_pass++;
        n_checks++; if (conflict_cnt !== '0) $display("FAIL rst_conflict_cnt: got %h expected 0", conflict_cnt); else n_pass++;
        n_checks++;
        if ({ram_we_a, ram_re_a, ram_we_b, ram_re_b} !== 4'h0)
            $display("FAIL rst_ram_en: got %b expected 0000", {ram_we_a, ram_re_a, ram_we_b, ram_re_b});
        else n_pass++;
        @(posedge clk);
        model_commit();
        #1;
        ram_clr = 1'b0;
        clr_req();
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        set_req(0, 1, 4'd3, 8'hA5);
        settle();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL wr_gnt: got %b expected 0001", gnt); else n_pass++;
        n_checks++;
        if ({ram_addr_a, ram_din_a, ram_we_a, ram_re_a} !== {4'd3, 8'hA5, 1'b1, 1'b0})
            $display("FAIL wr_port_a: got %h expected %h", {ram_addr_a, ram_din_a, ram_we_a, ram_re_a}, {4'd3, 8'hA5, 2'b10});
        else n_pass++;
        tick();
        set_req(0, 0, 4'd3, 8'h00);
        settle();
        n_checks++;
        if ({gnt, ram_re_a} !== {4'b0001, 1'b1}) $display("FAIL rd_gnt: got %b/%b expected 0001/1", gnt, ram_re_a);
        else n_pass++;
        tick();
        clr_req();
        settle();
        n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL rd_rsp_valid: got %b expected 0001", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 32'h000000A5) $display("FAIL rd_rsp_data: got %h expected 000000a5", rsp_data); else n_pass++;
        tick();
    endtask

    task automatic test_dual_grant();
        apply_reset();
        set_req(0, 1, 4'd1, 8'h11);
        set_req(1, 1, 4'd2, 8'h22);
        settle();
        n_checks++; if (gnt !== 4'b0011) $display("FAIL dual_gnt: got %b expected 0011", gnt); else n_pass++;
        n_checks++;
        if ({ram_addr_a, ram_addr_b, ram_we_a, ram_we_b} !== {4'd1, 4'd2, 2'b11})
            $display("FAIL dual_ports: got %h expected %h", {ram_addr_a, ram_addr_b, ram_we_a, ram_we_b}, {4'd1, 4'd2, 2'b11});
        else n_pass++;
        tick();
        // Pointer now sits at 2, so requester 2 takes port A ahead of requester 0.
        clr_req();
        set_req(0, 0, 4'd2, 8'h00);
        set_req(2, 0, 4'd1, 8'h00);
        settle();
        n_checks++;
        if ({gnt, ram_addr_a, ram_addr_b} !== {4'b0101, 4'd1, 4'd2})
            $display("FAIL dual_ptr: got %h expected %h", {gnt, ram_addr_a, ram_addr_b}, {4'b0101, 4'd1, 4'd2});
        else n_pass++;
        tick();
        clr_req();
        settle();
        n_checks++;
        if ({rsp_valid, rsp_data} !== {4'b0101, 32'h00110022})
            $display("FAIL dual_rsp: got %b/%h expected 0101/00110022", rsp_valid, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_hazard();
        apply_reset();
        set_req(0, 1, 4'd5, 8'h0F);
        set_req(2, 0, 4'd5, 8'h00);
        settle();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL haz_gnt: got %b expected 0001", gnt); else n_pass++;
        n_checks++;
        if ({ram_addr_b, ram_we_b, ram_re_b} !== 6'h0) $display("FAIL haz_port_b: got %h expected 0", {ram_addr_b, ram_we_b, ram_re_b});
        else n_pass++;
        tick();
        req[0] = 1'b0;
        settle();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL haz_gnt2: got %b expected 0100", gnt); else n_pass++;
        n_checks++; if (conflict_cnt !== 4'd1) $display("FAIL haz_cnt: got %0d expected 1", conflict_cnt); else n_pass++;
        tick();
        clr_req();
        settle();
        n_checks++;
        if ({rsp_valid, rsp_data[23:16]} !== {4'b0100, 8'h0F})
            $display("FAIL haz_rsp: got %b/%h expected 0100/0f", rsp_valid, rsp_data[23:16]);
        else n_pass++;
        tick();
    endtask

    task automatic test_fairness();
        int cnt [N];
        logic [N-1:0] exp_g;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 0, 4'd5, 8'h00);
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) clr_req();
            settle();
            if (c < 8) begin
                exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
                n_checks++; if (gnt !== exp_g) $display("FAIL fair_gnt c%0d: got %b expected %b", c, gnt, exp_g); else n_pass++;
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    cnt[i]++;
                    n_checks++;
                    if (rsp_data[i*DW +: DW] !== 8'h0F) $display("FAIL fair_data r%0d: got %h expected 0f", i, rsp_data[i*DW +: DW]);
                    else n_pass++;
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (cnt[i] !== 4) $display("FAIL fair_count r%0d: got %0d expected 4", i, cnt[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_req(2, 0, 4'd3, 8'h00);
        settle();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL mid_gnt1: got %b expected 0100", gnt); else n_pass++;
        tick();
        settle();
        n_checks++;
        if ({gnt, rsp_valid, rsp_data} !== {4'b0100, 4'b0100, 32'h00A50000})
            $display("FAIL mid_back_to_back: got %b/%b/%h expected 0100/0100/00a50000", gnt, rsp_valid, rsp_data);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'h0) $display("FAIL mid_gnt_in_reset: got %b expected 0000", gnt); else n_pass++;
        @(posedge clk);
        model_commit();
        #1;
        clr_req();
        rst = 1'b1;
        settle();
        n_checks++; if (rsp_valid !== 4'h0) $display("FAIL mid_rsp_lost: got %b expected 0000", rsp_valid); else n_pass++;
        tick();
        set_req(2, 0, 4'd3, 8'h00);
        set_req(3, 0, 4'd5, 8'h00);
        settle();
        n_checks++;
        if ({gnt, ram_addr_a, ram_addr_b} !== {4'b1100, 4'd3, 4'd5})
            $display("FAIL mid_ptr_reset: got %h expected %h", {gnt, ram_addr_a, ram_addr_b}, {4'b1100, 4'd3, 4'd5});
        else n_pass++;
        tick();
        clr_req();
        settle();
        n_checks++;
        if ({rsp_valid, rsp_data} !== {4'b1100, 32'h0FA50000})
            $display("FAIL mid_reissue: got %b/%h expected 1100/0fa50000", rsp_valid, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        logic [N-1:0] exp_g;
        apply_reset();
        set_req(0, 1, 4'd7, 8'($urandom_range(0, 255)));
        set_req(1, 0, 4'd7, 8'h00);
        for (int c = 0; c < 20; c++) begin
            settle();
            exp_cnt = (c < CNT_MAX) ? c : CNT_MAX;
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            n_checks++; if (gnt !== exp_g) $display("FAIL sat_gnt c%0d: got %b expected %b", c, gnt, exp_g); else n_pass++;
            n_checks++; if (conflict_cnt !== CW'(exp_cnt)) $display("FAIL sat_cnt c%0d: got %0d expected %0d", c, conflict_cnt, exp_cnt); else n_pass++;
            tick();
        end
        clr_req();
        settle();
        n_checks++; if (conflict_cnt !== CW'(CNT_MAX)) $display("FAIL sat_final: got %0d expected %0d", conflict_cnt, CNT_MAX); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        bit pending [N];
        for (int i = 0; i < N; i++) pending[i] = 0;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                    pending[i] = 1;
                end else if (!pending[i]) begin
                    req[i] = 1'b0;
                end
            end
            settle();
            n_checks++; if (gnt !== e_gnt) $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt, e_gnt); else n_pass++;
            n_checks++;
            if ({ram_addr_a, ram_din_a, ram_we_a, ram_re_a} !== e_port_a)
                $display("FAIL rnd_port_a c%0d: got %h expected %h", c, {ram_addr_a, ram_din_a, ram_we_a, ram_re_a}, e_port_a);
            else n_pass++;
            n_checks++;
            if ({ram_addr_b, ram_din_b, ram_we_b, ram_re_b} !== e_port_b)
                $display("FAIL rnd_port_b c%0d: got %h expected %h", c, {ram_addr_b, ram_din_b, ram_we_b, ram_re_b}, e_port_b);
            else n_pass++;
            n_checks++;
            if ({rsp_valid, rsp_data} !== {m_rsp_v, m_rsp_d})
                $display("FAIL rnd_rsp c%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, m_rsp_v, m_rsp_d);
            else n_pass++;
            n_checks++;
            if (conflict_cnt !== CW'(m_cnt)) $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, conflict_cnt, m_cnt); else n_pass++;
            tick();
            for (int i = 0; i < N; i++) if (e_gnt[i]) pending[i] = 0;
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        test_reset();
        test_write_read();
        test_dual_grant();
        test_hazard();
        test_fairness();
        test_reset_mid_read();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
